// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM (IDLE/REQ/WAIT/DONE) with PC, IR and deferred redirect.
// Optional WAIT timeout with sticky fetch_fault when FETCH_TIMEOUT_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instruction_read,
  input  logic        ir_write,
  input  logic        next_address_select,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] ir,
  output logic [5:0]  op_code,
  output logic        busy,
  output logic        fetch_fault
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0]  state;
  logic        pend_v;
  logic [31:0] pend_t;
  logic [31:0] tgt;
  logic        red_v;
  logic [31:0] red_t;
  logic        timeout;
  logic        unused_bt;
  assign unused_bt = &branch_target[1:0];
  assign tgt       = {branch_target[31:2], 2'b00};
  // a redirect arriving in the completing cycle is newer than any pending one
  assign red_v     = next_address_select | pend_v;
  assign red_t     = next_address_select ? tgt : pend_t;
  assign imem_req  = (state == REQ) || (state == WAIT);
  assign imem_addr = pc;
  assign npc       = pc + 32'd4;
  assign op_code   = ir[31:26];
  assign busy      = state != IDLE;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  assign timeout = (state == WAIT) && !imem_ready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wait_cnt    <= '0;
      fetch_fault <= 1'b0;
    end else begin
      wait_cnt    <= (state == WAIT && !imem_ready) ? wait_cnt + 1'b1 : '0;
      fetch_fault <= fetch_fault | timeout;
    end
`else
  assign timeout     = 1'b0;
  assign fetch_fault = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      ir     <= '0;
      pend_v <= 1'b0;
      pend_t <= '0;
    end else begin
      case (state)
        IDLE:
          if (next_address_select) pc <= tgt;
          else if (ir_write && instruction_read) state <= REQ;
        REQ, WAIT:
          if (imem_ready) begin
            ir     <= imem_rdata;
            pc     <= red_v ? red_t : pc + 32'd4;
            pend_v <= 1'b0;
            state  <= DONE;
          end else if (timeout) begin
            pend_v <= 1'b0;
            state  <= IDLE;
          end else begin
            state <= WAIT;
            if (next_address_select) begin
              pend_v <= 1'b1;
              pend_t <= tgt;
            end
          end
        default: begin
          if (red_v) pc <= red_t;
          pend_v <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; completed fetches are checked in DONE.
module tb_fetch_unit;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        instruction_read = 0;
  logic        ir_write = 0;
  logic        next_address_select = 0;
  logic [31:0] branch_target = 0;
  logic [31:0] imem_rdata = 0;
  logic        imem_ready = 0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] ir;
  logic [5:0]  op_code;
  logic        busy;
  logic        fetch_fault;
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  int          ir_chg = 0;
  logic [31:0] ir_prev = 0;
  logic [63:0] sb[$];
  logic [63:0] e;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .instruction_read(instruction_read), .ir_write(ir_write),
    .next_address_select(next_address_select), .branch_target(branch_target),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc(pc), .npc(npc), .ir(ir), .op_code(op_code),
    .busy(busy), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (ir !== ir_prev) ir_chg++;
    ir_prev = ir;
    if (rst_n && busy && !imem_req) begin
      if (sb.size() == 0) check("sb_extra", 1, 0);
      else begin
        e = sb.pop_front();
        check("done_ir", ir, e[63:32]);
        check("done_pc", pc, e[31:0]);
        check("done_op", {26'd0, op_code}, {26'd0, e[63:58]});
      end
    end
  end

  task automatic fetch(input logic [31:0] rdata, input int dly, input logic [31:0] exp_addr,
                       input logic [31:0] exp_pc, input logic redir, input logic [31:0] rt);
    logic [31:0] ir0;
    ir0 = ir;
    sb.push_back({rdata, exp_pc});
    imem_rdata = rdata;
    ir_write = 1;
    instruction_read = 1;
    @(posedge clk); #1;
    ir_write = 0;
    instruction_read = 0;
    check("req", imem_req, 1);
    check("req_addr", imem_addr, exp_addr);
    check("lat_pre", ir, ir0);
    for (int i = 0; i < dly; i++) begin
      if (redir && i == 1) begin
        next_address_select = 1;
        branch_target = rt;
      end
      @(posedge clk); #1;
      next_address_select = 0;
      check("addr_hold", imem_addr, exp_addr);
    end
    imem_ready = 1;
    @(posedge clk); #1;
    imem_ready = 0;
    @(posedge clk); #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    next_address_select = 1;
    branch_target = t;
    @(posedge clk); #1;
    next_address_select = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_busy", busy, 0);
    check("rst_fault", fetch_fault, 0);
    rst_n = 1;
    @(posedge clk); #1;
    fetch(32'h2800_0010, 0, 32'h0, 32'h4, 0, 0);
    check("op_code", {26'd0, op_code}, 32'h0000_000A);
    check("npc", npc, 32'h8);
    busy_cnt = 0;
    ir_chg = 0;
    fetch(32'h1234_5678, 5, 32'h4, 32'h8, 0, 0);
    check("busy_cycles", busy_cnt, 7);
    check("ir_updates", ir_chg, 1);
    ir_write = 1;
    @(posedge clk); #1;
    ir_write = 0;
    check("irw_only_busy", busy, 0);
    redirect(32'h0000_0103);
    check("idle_redir_pc", pc, 32'h100);
    fetch(32'hA5A5_0001, 0, 32'h100, 32'h104, 0, 0);
    fetch(32'h0C00_0002, 3, 32'h104, 32'h40, 1, 32'h40);
    next_address_select = 1;
    branch_target = 32'h200;
    ir_write = 1;
    instruction_read = 1;
    @(posedge clk); #1;
    next_address_select = 0;
    ir_write = 0;
    instruction_read = 0;
    check("race_pc", pc, 32'h200);
    @(posedge clk); #1;
    check("race_busy", busy, 0);
    redirect(32'hFFFF_FFFE);
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    fetch(32'hDEAD_BEEF, 0, 32'hFFFF_FFFC, 32'h0, 0, 0);
    check("wrap_npc", npc, 32'h4);
    redirect(32'h80);
    ir_write = 1;
    instruction_read = 1;
    @(posedge clk); #1;
    ir_write = 0;
    instruction_read = 0;
    @(posedge clk); #1;
    check("mid_wait_req", imem_req, 1);
    rst_n = 0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_ir", ir, 32'h0);
    check("arst_busy", busy, 0);
    check("arst_req", imem_req, 0);
    #5 rst_n = 1;
    imem_ready = 1;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_idle", busy, 0);
    end
    imem_ready = 0;
`ifdef FETCH_TIMEOUT_EN
    busy_cnt = 0;
    ir_write = 1;
    instruction_read = 1;
    @(posedge clk); #1;
    ir_write = 0;
    instruction_read = 0;
    for (int i = 0; i < 400 && busy; i++) @(posedge clk);
    #1;
    check("to_idle", busy, 0);
    check("to_busy_cycles", busy_cnt, 256);
    check("to_fault", fetch_fault, 1);
    check("to_pc", pc, 32'h0);
    check("to_ir", ir, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("to_sticky", fetch_fault, 1);
    rst_n = 0;
    #1;
    check("to_rst", fetch_fault, 0);
    #5 rst_n = 1;
    @(posedge clk); #1;
`else
    fetch(32'h1111_2222, 300, 32'h0, 32'h4, 0, 0);
    check("no_fault", fetch_fault, 0);
`endif
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
